rr_trace_marshaller2: RTL and testbench

// - Binary node of the record-side trace encoder tree: joins two packed trace buses into one.
// - Left (A) carries the low channels, right (B) the high channels.
// - B's compacted logb_data is shifted down to sit directly after A's valid payload.
// - logb_valid/loge_valid vectors are concatenated; the root output feeds rr_stream_bus_t packing.

---
 rtl/rr_trace_marshaller2_if.sv | 28 ++
 rtl/rr_trace_marshaller2.sv | 163 ++++++++++++++++
 tb/tb_rr_trace_marshaller2.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_trace_marshaller2_if.sv
// Packed trace bus carrying one marshaller side (or the merged output).
//   valid       source -> sink   packet valid
//   ready       sink -> source   packet accepted when valid & ready
//   logb_valid  source -> sink   per-channel logb valid, LOGB_CNT bits
//   logb_data   source -> sink   compacted payload, LSB-aligned, DATA_W bits
//   loge_valid  source -> sink   loge bits, LOGE_CNT bits
// master = producer of the packet, slave = consumer.
interface rr_trace_marshaller2_if #(
  parameter int unsigned LOGB_CNT = 2,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned LOGE_CNT = 2
);
  logic                valid;
  logic                ready;
  logic [LOGB_CNT-1:0] logb_valid;
  logic [DATA_W-1:0]   logb_data;
  logic [LOGE_CNT-1:0] loge_valid;

  modport master (
    output valid, logb_valid, logb_data, loge_valid,
    input  ready
  );

  modport slave (
    input  valid, logb_valid, logb_data, loge_valid,
    output ready
  );
endinterface

// File: rtl/rr_trace_marshaller2.sv
// rr_trace_marshaller2: binary node of the record-side trace encoder tree.
// Joins packed trace bus A (low channels) and B (high channels) into one bus.
// B's compacted payload is shifted down to sit directly after A's valid payload;
// logb/loge valid vectors are concatenated as {B, A}.
//
// Ports:
//   clk       clock
//   rstn      synchronous reset, active-low
//   skew_err  sticky skew violation (present only with RR_MARSHALLER_SKEW_CHECK_EN)
//   a_bus     slave,  side A: LOGB_LEFT_CNT  logb bits, LW data bits, LOGE_LEFT_CNT loge bits
//   b_bus     slave,  side B: LOGB_RIGHT_CNT logb bits, RW data bits, LOGE_RIGHT_CNT loge bits
//   out_bus   master, merged: L+R logb bits, FW data bits, LEL+LER loge bits
//
// Optional feature macro: RR_MARSHALLER_SKEW_CHECK_EN
//   When defined, a saturating counter tracks consecutive cycles in which exactly
//   one holding register is full; skew_err sets (sticky) when it reaches SKEW_LIMIT.
module rr_trace_marshaller2 #(
  parameter int unsigned LOGB_LEFT_CNT         = 2,
  parameter int unsigned LOGB_RIGHT_CNT        = 2,
  parameter int unsigned RR_CHANNEL_WIDTH_BITS = 16,
  parameter bit [LOGB_LEFT_CNT+LOGB_RIGHT_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {16'd64, 16'd32, 16'd16, 16'd8},
  parameter int unsigned LOGE_LEFT_CNT         = 2,
  parameter int unsigned LOGE_RIGHT_CNT        = 2
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
  , parameter int unsigned SKEW_LIMIT          = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rstn,
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
  output logic                        skew_err,
`endif
  rr_trace_marshaller2_if.slave       a_bus,
  rr_trace_marshaller2_if.slave       b_bus,
  rr_trace_marshaller2_if.master      out_bus
);

  function automatic int unsigned width_sum(int unsigned lo, int unsigned cnt);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < cnt; i++) s += 32'(CHANNEL_WIDTHS[lo + i]);
    return s;
  endfunction

  localparam int unsigned LC = LOGB_LEFT_CNT + LOGB_RIGHT_CNT;
  localparam int unsigned EC = LOGE_LEFT_CNT + LOGE_RIGHT_CNT;
  localparam int unsigned LW = width_sum(0, LOGB_LEFT_CNT);
  localparam int unsigned RW = width_sum(LOGB_LEFT_CNT, LOGB_RIGHT_CNT);
  localparam int unsigned FW = LW + RW;
  localparam int unsigned OW = $clog2(FW + 1);

  // Holding registers, one per side
  logic                      ha_full, hb_full;
  logic [LOGB_LEFT_CNT-1:0]  ha_lv;
  logic [LOGB_RIGHT_CNT-1:0] hb_lv;
  logic [LW-1:0]             ha_data;
  logic [RW-1:0]             hb_data;
  logic [LOGE_LEFT_CNT-1:0]  ha_le;
  logic [LOGE_RIGHT_CNT-1:0] hb_le;

  // Output register
  logic                      out_valid_q;
  logic [LC-1:0]             out_lv_q;
  logic [FW-1:0]             out_data_q;
  logic [EC-1:0]             out_le_q;

  logic                      fire;
  logic [OW-1:0]             len_l;
  logic [FW-1:0]             merged;

  assign fire        = ha_full & hb_full & (~out_valid_q | out_bus.ready);
  assign a_bus.ready = ~ha_full | fire;
  assign b_bus.ready = ~hb_full | fire;

  // Payload length of A: sum of widths of its valid channels
  always_comb begin
    len_l = '0;
    for (int unsigned i = 0; i < LOGB_LEFT_CNT; i++)
      if (ha_lv[i]) len_l = len_l + OW'(CHANNEL_WIDTHS[i]);
  end

  // Inputs are zero above their payload length, so OR-ing needs no mask
  assign merged = FW'(ha_data) | (FW'(hb_data) << len_l);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ha_full <= 1'b0;
      ha_lv   <= '0;
      ha_data <= '0;
      ha_le   <= '0;
    end else if (a_bus.valid && a_bus.ready) begin
      ha_full <= 1'b1;
      ha_lv   <= a_bus.logb_valid;
      ha_data <= a_bus.logb_data;
      ha_le   <= a_bus.loge_valid;
    end else if (fire) begin
      ha_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hb_full <= 1'b0;
      hb_lv   <= '0;
      hb_data <= '0;
      hb_le   <= '0;
    end else if (b_bus.valid && b_bus.ready) begin
      hb_full <= 1'b1;
      hb_lv   <= b_bus.logb_valid;
      hb_data <= b_bus.logb_data;
      hb_le   <= b_bus.loge_valid;
    end else if (fire) begin
      hb_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_lv_q    <= '0;
      out_data_q  <= '0;
      out_le_q    <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_lv_q    <= {hb_lv, ha_lv};
      out_data_q  <= merged;
      out_le_q    <= {hb_le, ha_le};
    end else if (out_bus.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_bus.valid      = out_valid_q;
  assign out_bus.logb_valid = out_lv_q;
  assign out_bus.logb_data  = out_data_q;
  assign out_bus.loge_valid = out_le_q;

`ifdef RR_MARSHALLER_SKEW_CHECK_EN
  localparam int unsigned SCW = $clog2(SKEW_LIMIT + 1);

  logic [SCW-1:0] skew_cnt, skew_cnt_nxt;

  always_comb begin
    skew_cnt_nxt = '0;
    if (ha_full ^ hb_full) begin
      if (skew_cnt == SCW'(SKEW_LIMIT)) skew_cnt_nxt = skew_cnt;
      else                              skew_cnt_nxt = skew_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      skew_cnt <= '0;
      skew_err <= 1'b0;
    end else begin
      skew_cnt <= skew_cnt_nxt;
      if (skew_cnt_nxt == SCW'(SKEW_LIMIT)) skew_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_trace_marshaller2.sv
// Scoreboard bench for rr_trace_marshaller2 (widths ch0=8, ch1=16, ch2=32, ch3=64).
// Drivers feed per-side packet queues; directed tests push hand-computed expected
// merged packets; a monitor pops and compares on every output handshake.
module tb_rr_trace_marshaller2;

  typedef struct packed {
    logic [1:0]  lv;
    logic [23:0] data;
    logic [1:0]  le;
  } a_pkt_t;

  typedef struct packed {
    logic [1:0]  lv;
    logic [95:0] data;
    logic [1:0]  le;
  } b_pkt_t;

  typedef struct packed {
    logic [3:0]   lv;
    logic [119:0] data;
    logic [3:0]   le;
  } o_pkt_t;

  logic clk;
  logic rstn;
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
  logic skew_err;
`endif

  rr_trace_marshaller2_if #(.LOGB_CNT(2), .DATA_W(24),  .LOGE_CNT(2)) a_bus();
  rr_trace_marshaller2_if #(.LOGB_CNT(2), .DATA_W(96),  .LOGE_CNT(2)) b_bus();
  rr_trace_marshaller2_if #(.LOGB_CNT(4), .DATA_W(120), .LOGE_CNT(4)) out_bus();

  rr_trace_marshaller2 #(
    .LOGB_LEFT_CNT(2),
    .LOGB_RIGHT_CNT(2),
    .RR_CHANNEL_WIDTH_BITS(16),
    .CHANNEL_WIDTHS({16'd64, 16'd32, 16'd16, 16'd8}),
    .LOGE_LEFT_CNT(2),
    .LOGE_RIGHT_CNT(2)
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
    , .SKEW_LIMIT(4)
`endif
  ) dut (
    .clk(clk),
    .rstn(rstn),
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
    .skew_err(skew_err),
`endif
    .a_bus(a_bus),
    .b_bus(b_bus),
    .out_bus(out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  a_pkt_t aq[$];
  b_pkt_t bq[$];
  o_pkt_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Main process acts at negedge+1; drivers at negedge; monitor at negedge+3.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // A-side driver
  always begin
    @(negedge clk);
    if (aq.size() > 0) begin
      a_bus.valid      = 1'b1;
      a_bus.logb_valid = aq[0].lv;
      a_bus.logb_data  = aq[0].data;
      a_bus.loge_valid = aq[0].le;
    end else begin
      a_bus.valid      = 1'b0;
      a_bus.logb_valid = '0;
      a_bus.logb_data  = '0;
      a_bus.loge_valid = '0;
    end
    #3;
    if (rstn && a_bus.valid && a_bus.ready) void'(aq.pop_front());
  end

  // B-side driver
  always begin
    @(negedge clk);
    if (bq.size() > 0) begin
      b_bus.valid      = 1'b1;
      b_bus.logb_valid = bq[0].lv;
      b_bus.logb_data  = bq[0].data;
      b_bus.loge_valid = bq[0].le;
    end else begin
      b_bus.valid      = 1'b0;
      b_bus.logb_valid = '0;
      b_bus.logb_data  = '0;
      b_bus.loge_valid = '0;
    end
    #3;
    if (rstn && b_bus.valid && b_bus.ready) void'(bq.pop_front());
  end

  // Monitor: scoreboard compare on handshake, stability check while stalled
  logic   prev_stall = 1'b0;
  o_pkt_t prev_out;
  always begin
    o_pkt_t e;
    @(negedge clk);
    #3;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 128'(out_bus.valid), 128'(1'b1));
        chk("stall_lv",    128'(out_bus.logb_valid), 128'(prev_out.lv));
        chk("stall_data",  128'(out_bus.logb_data),  128'(prev_out.data));
        chk("stall_le",    128'(out_bus.loge_valid), 128'(prev_out.le));
      end
      if (out_bus.valid && out_bus.ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got lv=%h data=%h le=%h expected none",
                   out_bus.logb_valid, out_bus.logb_data, out_bus.loge_valid);
        end else begin
          e = exp_q.pop_front();
          chk("out_lv",   128'(out_bus.logb_valid), 128'(e.lv));
          chk("out_data", 128'(out_bus.logb_data),  128'(e.data));
          chk("out_le",   128'(out_bus.loge_valid), 128'(e.le));
        end
      end
      prev_stall    = out_bus.valid && !out_bus.ready;
      prev_out.lv   = out_bus.logb_valid;
      prev_out.data = out_bus.logb_data;
      prev_out.le   = out_bus.loge_valid;
    end
  end

  task automatic push_a(input logic [1:0] lv, input logic [23:0] d, input logic [1:0] le);
    aq.push_back('{lv: lv, data: d, le: le});
  endtask

  task automatic push_b(input logic [1:0] lv, input logic [95:0] d, input logic [1:0] le);
    bq.push_back('{lv: lv, data: d, le: le});
  endtask

  task automatic push_exp(input logic [3:0] lv, input logic [119:0] d, input logic [3:0] le);
    exp_q.push_back('{lv: lv, data: d, le: le});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || aq.size() != 0 || bq.size() != 0 || out_bus.valid) && n < 200) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s: drain timeout, exp left %0d, a left %0d, b left %0d expected all 0",
               name, exp_q.size(), aq.size(), bq.size());
    end
  endtask

  initial begin
    logic [23:0] ad;
    logic [95:0] bd;
    logic [1:0]  al;

    rstn            = 1'b0;
    out_bus.ready   = 1'b1;
    a_bus.valid     = 1'b0;
    b_bus.valid     = 1'b0;
    cyc(3);

    // Reset state
    chk("rst_out_valid", 128'(out_bus.valid), 128'(1'b0));
    chk("rst_out_lv",    128'(out_bus.logb_valid), 128'(0));
    chk("rst_out_data",  128'(out_bus.logb_data),  128'(0));
    chk("rst_out_le",    128'(out_bus.loge_valid), 128'(0));
    chk("rst_a_ready",   128'(a_bus.ready), 128'(1'b1));
    chk("rst_b_ready",   128'(b_bus.ready), 128'(1'b1));
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
    chk("rst_skew_err",  128'(skew_err), 128'(1'b0));
`endif
    rstn = 1'b1;
    cyc(1);

    // Merge: A ch1 (16b) valid, B ch2 (32b) valid; B lands at bit 16; latency 2
    push_a(2'b10, 24'h00BEEF, 2'b00);
    push_b(2'b01, 96'hCAFEF00D, 2'b00);
    push_exp(4'b0110, 120'hCAFE_F00D_BEEF, 4'b0000);
    cyc(2);
    chk("latency_not_early", 128'(out_bus.valid), 128'(1'b0));
    cyc(1);
    chk("latency_valid", 128'(out_bus.valid), 128'(1'b1));
    wait_drain("merge");

    // Empty logb: loge still propagates
    push_a(2'b00, 24'h0, 2'b01);
    push_b(2'b00, 96'h0, 2'b10);
    push_exp(4'b0000, 120'h0, 4'b1001);
    wait_drain("empty_logb");

    // Backpressure: both sides streaming, out_ready low for 5 cycles
    out_bus.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ad = 24'h102030 + 24'(i);
      bd = {64'h0123456789ABCDEF + 64'(i), 32'hFEED0000 + 32'(i)};
      al = 2'(i);
      push_a(2'b11, ad, al);
      push_b(2'b11, bd, ~al);
      push_exp(4'b1111, {bd, ad}, {~al, al});
    end
    cyc(5);
    chk("bp_a_ready", 128'(a_bus.ready), 128'(1'b0));
    chk("bp_b_ready", 128'(b_bus.ready), 128'(1'b0));
    out_bus.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bp_throughput", 128'(out_bus.valid), 128'(1'b1));
      cyc(1);
    end
    wait_drain("backpressure");

    // Skew: A sends 3 while B is silent, then B sends 3; pairing by arrival order
    for (int i = 0; i < 3; i++) push_a(2'b01, 24'h0000C0 + 24'(i), 2'b11);
    cyc(8);
    chk("skew_a_ready", 128'(a_bus.ready), 128'(1'b0));
    chk("skew_a_left",  128'(aq.size()), 128'(2));
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
    chk("skew_err_set", 128'(skew_err), 128'(1'b1));
`endif
    for (int i = 0; i < 3; i++) begin
      bd = 96'(64'hDEADBEEF00000000 + 64'(i));
      push_b(2'b10, bd, 2'b00);
      push_exp(4'b1001, 120'({bd[63:0], 8'hC0 + 8'(i)}), 4'b0011);
    end
    wait_drain("skew");
`ifdef RR_MARSHALLER_SKEW_CHECK_EN
    chk("skew_err_sticky", 128'(skew_err), 128'(1'b1));
`endif

    // Reset mid-operation: out holds a packet, hA holds another
    out_bus.ready = 1'b0;
    push_a(2'b11, 24'h111111, 2'b01);
    push_b(2'b11, 96'h222222222222222222222222, 2'b10);
    cyc(3);
    chk("midrst_out_valid", 128'(out_bus.valid), 128'(1'b1));
    push_a(2'b11, 24'hBADBAD, 2'b11);
    cyc(3);
    chk("midrst_a_full", 128'(a_bus.ready), 128'(1'b0));
    rstn = 1'b0;
    exp_q.delete();
    cyc(1);
    rstn = 1'b1;
    chk("postrst_out_valid", 128'(out_bus.valid), 128'(1'b0));
    chk("postrst_a_ready",   128'(a_bus.ready), 128'(1'b1));
    chk("postrst_b_ready",   128'(b_bus.ready), 128'(1'b1));
    out_bus.ready = 1'b1;
    push_a(2'b11, 24'h333333, 2'b00);
    push_b(2'b11, 96'h444444444444444444444444, 2'b00);
    push_exp(4'b1111, {96'h444444444444444444444444, 24'h333333}, 4'b0000);
    wait_drain("reset_midop");
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
